rf_wb_port_arbiter: RTL and testbench
=====================================

// Module: rf_wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline WB stage and the
//  multi-cycle long-latency unit (mul/div). Buffers long-unit results in a small FIFO, keeps a
//  per-register busy scoreboard for the hazard unit, and drives rf_we/rf_waddr/rf_wdata directly.
// PARAMETERS
//  DATA_W        32  write data width
//  ADDR_W        5   register address width
//  BUF_DEPTH     2   long-unit result FIFO entries (>=1)
//  STARVE_LIMIT  4   consecutive lost cycles before stall_req (ARB_FAIRNESS_EN only)
// PORTS
//  clk        in   1        clock; all state updates on rising edge
//  reset      in   1        synchronous, active-high
//  pipe_we    in   1        pipeline WB write request
//  pipe_waddr in   ADDR_W   pipeline destination register
//  pipe_wdata in   DATA_W   pipeline write data
//  lu_valid   in   1        long-unit result valid
//  lu_ready   out  1        arbiter can accept long-unit result
//  lu_waddr   in   ADDR_W   long-unit destination register
//  lu_wdata   in   DATA_W   long-unit result
//  iss_valid  in   1        long-unit op issued this cycle
//  iss_waddr  in   ADDR_W   destination of issued op
//  rf_we      out  1        register-file write enable
//  rf_waddr   out  ADDR_W   register-file write address
//  rf_wdata   out  DATA_W   register-file write data
//  busy_vec   out  32       bit r = long-unit write to r pending; bit 0 always 0
//  stall_req  out  1        request pipeline freeze for one cycle
//  buf_count  out  $clog2(BUF_DEPTH+1)  FIFO occupancy
// BEHAVIOUR
//  - Reset (sync): FIFO emptied, busy_vec=0, starve counter=0, buf_count=0; outputs then
//    rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, lu_ready=1. Reset mid-operation drops buffered results.
//  - lu_ready = (buf_count < BUF_DEPTH), from registered count only; a same-cycle pop never raises it.
//  - Accept = lu_valid & lu_ready. lu_waddr==0 accepted and discarded (not enqueued).
//  - rf_* combinational, zero latency: RF writes on the same edge the grant is made.
//  - Grant priority each cycle: (1) stall_req=1 -> FIFO head; (2) pipe_we & pipe_waddr!=0 -> pipeline;
//    (3) FIFO non-empty -> head; (4) FIFO empty & accepted lu result -> pass-through (push+pop same cycle);
//    else rf_we=0. Pipeline writes to $0 never take the port.
//  - Pipeline is never back-pressured except via stall_req; it never loses a write.
//  - FIFO in-order; simultaneous push and pop at full allowed only if accepted earlier (ready low at full).
//  - busy_vec: iss_valid & iss_waddr!=0 sets bit at edge; long-unit commit clears bit at same edge.
//    Set and clear same register same cycle -> set wins. Pipeline writes do not touch busy_vec.
//  - Contract: hazard unit stalls any instruction reading or writing a busy register; arbiter does
//    not check WAW ordering.
//  - buf_count never exceeds BUF_DEPTH; pop on empty never occurs.
// CONFIGURATION
//  ARB_FAIRNESS_EN defined: counter increments each cycle FIFO non-empty and pipeline wins; clears
//    when FIFO wins or is empty; saturates. stall_req = (counter==STARVE_LIMIT), combinational from state.
//    In a stall_req cycle the FIFO head is granted, pipeline holds and re-presents its write next cycle.
//  ARB_FAIRNESS_EN undefined: no counter, stall_req tied 0, pipeline always wins.
// STRUCTURE
//  - Package rf_arb_pkg: ADDR_W, DATA_W constants; typedef wb_entry_t {waddr, wdata}; grant enum
//    {GNT_NONE, GNT_PIPE, GNT_FIFO, GNT_PASS}.
//  - Sub-module wb_skid_fifo: BUF_DEPTH-entry circular FIFO of wb_entry_t, push/pop/count, wrap-around pointers.
//  - Top: grant mux, scoreboard, starve counter.
// TESTING
//  1. Reset held 2 cycles mid-traffic -> rf_we=0, busy_vec=0, buf_count=0, lu_ready=1 next cycle.
//  2. FIFO empty, pipe_we=0, lu_valid with $8=0x1234 -> rf_we=1, rf_waddr=8, rf_wdata=0x1234 same cycle, busy[8] cleared.
//  3. pipe_we to $9 every cycle, two lu results ($10,$11) -> buffered, buf_count=2, lu_ready=0; drained in order when pipe_we drops.
//  4. iss_valid $12 and $12 commit same cycle -> busy[12] stays 1; pipe_we to $0 with FIFO head -> FIFO granted.
//  5. ARB_FAIRNESS_EN, STARVE_LIMIT=4, pipe_we constant, FIFO holds 1 -> stall_req=1 in 5th cycle, FIFO granted, then 0.
//  6. Fill FIFO, wrap pointers 3x with random pipe traffic -> scoreboard model matches rf write order exactly.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: entry layout and grant encoding.
package rf_arb_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_FIFO = 2'd2,
    GNT_PASS = 2'd3
  } grant_t;
endpackage

// File: rtl/wb_skid_fifo.sv
// Circular FIFO holding long-unit results until the register-file port is free.
module wb_skid_fifo
  import rf_arb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  wb_entry_t     din,
  input  logic          pop,
  output wb_entry_t     head,
  output logic [CW-1:0] count
);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/rf_wb_port_arbiter.sv
// Arbitrates the single RF write port between pipeline WB and the long-latency unit.
// Optional starvation guard enabled by defining ARB_FAIRNESS_EN.
module rf_wb_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter  int BUF_DEPTH    = 2
`ifdef ARB_FAIRNESS_EN
  ,
  parameter  int STARVE_LIMIT = 4
`endif
  ,
  localparam int CNT_W = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_waddr,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       busy_vec,
  output logic              stall_req,
  output logic [CNT_W-1:0]  buf_count
);

  grant_t      grant;
  wb_entry_t   head;
  logic        fifo_empty;
  logic        lu_take;
  logic        fifo_push;
  logic        fifo_pop;
  logic        commit;
  logic [ADDR_W-1:0] commit_addr;
  logic [31:0] busy_nxt;

  assign fifo_empty = (buf_count == CNT_W'(0));
  assign lu_ready   = (buf_count < CNT_W'(BUF_DEPTH));
  // Results for $0 are consumed but never stored or written.
  assign lu_take    = lu_valid & lu_ready & ~reset & (lu_waddr != ADDR_W'(0));

  always_comb begin
    grant = GNT_NONE;
    if (reset)                                     grant = GNT_NONE;
    else if (stall_req && !fifo_empty)             grant = GNT_FIFO;
    else if (pipe_we && pipe_waddr != ADDR_W'(0))  grant = GNT_PIPE;
    else if (!fifo_empty)                          grant = GNT_FIFO;
    else if (lu_take)                              grant = GNT_PASS;
    else                                           grant = GNT_NONE;
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (grant)
      GNT_PIPE: begin rf_we = 1'b1; rf_waddr = pipe_waddr; rf_wdata = pipe_wdata; end
      GNT_FIFO: begin rf_we = 1'b1; rf_waddr = head.waddr; rf_wdata = head.wdata; end
      GNT_PASS: begin rf_we = 1'b1; rf_waddr = lu_waddr;   rf_wdata = lu_wdata;   end
      default:  begin rf_we = 1'b0; rf_waddr = '0;         rf_wdata = '0;         end
    endcase
  end

  assign fifo_push = lu_take & (grant != GNT_PASS);
  assign fifo_pop  = (grant == GNT_FIFO);

  wb_skid_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   ('{waddr: lu_waddr, wdata: lu_wdata}),
    .pop   (fifo_pop),
    .head  (head),
    .count (buf_count)
  );

  assign commit      = (grant == GNT_FIFO) || (grant == GNT_PASS);
  assign commit_addr = (grant == GNT_FIFO) ? head.waddr : lu_waddr;

  // Issue is applied after commit so a same-register set/clear leaves the bit set.
  always_comb begin
    busy_nxt = busy_vec;
    if (commit) busy_nxt[commit_addr] = 1'b0;
    else        busy_nxt = busy_vec;
    if (iss_valid) busy_nxt[iss_waddr] = 1'b1;
    else           busy_nxt = busy_nxt;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_vec <= '0;
    else       busy_vec <= busy_nxt;
  end

`ifdef ARB_FAIRNESS_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve;

  assign stall_req = (starve == SW'(STARVE_LIMIT));

  // Counts consecutive cycles a waiting long-unit result lost to the pipeline.
  always_ff @(posedge clk) begin
    if (reset)                                         starve <= '0;
    else if (fifo_empty || grant == GNT_FIFO)          starve <= '0;
    else if (grant == GNT_PIPE && !stall_req)          starve <= starve + SW'(1);
    else                                               starve <= starve;
  end
`else
  assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_port_arbiter.sv
// Randomized + directed bench for rf_wb_port_arbiter against a queue-based reference model.
module tb_rf_wb_port_arbiter;
  import rf_arb_pkg::*;

  localparam int BUF_DEPTH    = 2;
  localparam int STARVE_LIMIT = 4;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR_EN = 1'b1;
`else
  localparam bit FAIR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        iss_valid;
  logic [4:0]  iss_waddr;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_vec;
  logic        stall_req;
  logic [1:0]  buf_count;

  rf_wb_port_arbiter #(.BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .iss_valid(iss_valid), .iss_waddr(iss_waddr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_vec(busy_vec), .stall_req(stall_req), .buf_count(buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: pending results as an ordered list, busy as a bit set.
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic [31:0] m_busy = '0;
  int          m_starve = 0;

  typedef struct {
    bit we; logic [4:0] a; logic [31:0] d;
    bit use_q; bit pass; bit take; bit stall; bit ready;
  } pred_t;

  function automatic pred_t predict();
    pred_t p;
    p.stall = FAIR_EN && (m_starve == STARVE_LIMIT);
    p.ready = (q.size() < BUF_DEPTH);
    p.take  = lu_valid && p.ready && (lu_waddr != 5'd0);
    p.we = 1'b0; p.a = 5'd0; p.d = 32'd0; p.use_q = 1'b0; p.pass = 1'b0;
    if (p.stall && q.size() > 0)             p.use_q = 1'b1;
    else if (pipe_we && pipe_waddr != 5'd0) begin p.we = 1'b1; p.a = pipe_waddr; p.d = pipe_wdata; end
    else if (q.size() > 0)                   p.use_q = 1'b1;
    else if (p.take)                         p.pass = 1'b1;
    if (p.use_q) begin p.we = 1'b1; p.a = q[0].a; p.d = q[0].d; end
    if (p.pass)  begin p.we = 1'b1; p.a = lu_waddr; p.d = lu_wdata; end
    return p;
  endfunction

  task automatic apply(input bit rst, input bit pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input bit iv, input logic [4:0] ia);
    pred_t p;
    @(negedge clk);
    reset = rst; pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld; iss_valid = iv; iss_waddr = ia;
    #1;
    if (!rst) begin
      p = predict();
      check_val("rf_we",     64'(rf_we),     64'(p.we));
      check_val("rf_waddr",  64'(rf_waddr),  64'(p.a));
      check_val("rf_wdata",  64'(rf_wdata),  64'(p.d));
      check_val("busy_vec",  64'(busy_vec),  64'(m_busy));
      check_val("buf_count", 64'(buf_count), 64'(q.size()));
      check_val("lu_ready",  64'(lu_ready),  64'(p.ready));
      check_val("stall_req", 64'(stall_req), 64'(p.stall));
    end
  endtask

  task automatic tick();
    pred_t p;
    bit was_empty;
    p = predict();
    was_empty = (q.size() == 0);
    @(posedge clk);
    if (reset) begin
      q.delete(); m_busy = '0; m_starve = 0;
    end else begin
      if (p.use_q) begin m_busy[q[0].a] = 1'b0; void'(q.pop_front()); end
      if (p.pass)  m_busy[lu_waddr] = 1'b0;
      if (p.take && !p.pass) q.push_back('{a: lu_waddr, d: lu_wdata});
      if (iss_valid && iss_waddr != 5'd0) m_busy[iss_waddr] = 1'b1;
      if (FAIR_EN) begin
        if (was_empty || p.use_q)        m_starve = 0;
        else if (m_starve < STARVE_LIMIT) m_starve++;
      end
    end
  endtask

  task automatic step(input bit rst, input bit pwe, input logic [4:0] pa, input logic [31:0] pd,
                      input bit lv, input logic [4:0] la, input logic [31:0] ld,
                      input bit iv, input logic [4:0] ia);
    apply(rst, pwe, pa, pd, lv, la, ld, iv, ia);
    tick();
  endtask

  task automatic rand_cycle(input int pipe_pct, input bit rst);
    step(rst, ($urandom_range(0, 99) < pipe_pct), 5'($urandom_range(0, 31)), $urandom,
         ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 31)), $urandom,
         ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 31)));
  endtask

  initial begin
    reset = 1'b1; pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0; iss_valid = 1'b0; iss_waddr = '0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Pass-through of $8 with busy clear
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd8);
    apply(0, 0, 0, 0, 1, 5'd8, 32'h1234, 0, 0);
    check_val("t2_we", 64'(rf_we), 64'd1);
    check_val("t2_waddr", 64'(rf_waddr), 64'd8);
    check_val("t2_wdata", 64'(rf_wdata), 64'h1234);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("t2_busy8", 64'(busy_vec[8]), 64'd0);
    tick();

    // Buffering behind continuous pipeline writes, then in-order drain
    step(0, 1, 5'd9, 32'h99, 1, 5'd10, 32'hA0, 0, 0);
    step(0, 1, 5'd9, 32'h99, 1, 5'd11, 32'hB0, 0, 0);
    apply(0, 1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
    check_val("t3_count", 64'(buf_count), 64'd2);
    check_val("t3_ready", 64'(lu_ready), 64'd0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("t3_drain0", 64'(rf_waddr), 64'd10);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("t3_drain1", 64'(rf_waddr), 64'd11);
    tick();

    // Same-cycle issue and commit of $12; pipeline $0 yields to FIFO
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd12);
    step(0, 0, 0, 0, 1, 5'd12, 32'hC0, 1, 5'd12);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("t4_busy12", 64'(busy_vec[12]), 64'd1);
    tick();
    step(0, 1, 5'd9, 32'h99, 1, 5'd13, 32'hD0, 0, 0);
    apply(0, 1, 5'd0, 32'h55, 0, 0, 0, 0, 0);
    check_val("t4_x0_we", 64'(rf_we), 64'd1);
    check_val("t4_x0_fifo", 64'(rf_waddr), 64'd13);
    tick();

`ifdef ARB_FAIRNESS_EN
    step(0, 1, 5'd9, 32'h99, 1, 5'd14, 32'hE0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      apply(0, 1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
      check_val("t5_stall", 64'(stall_req), 64'(i == 5));
      if (i == 5) check_val("t5_fifo_gnt", 64'(rf_waddr), 64'd14);
      tick();
    end
    apply(0, 1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
    check_val("t5_stall_after", 64'(stall_req), 64'd0);
    tick();
`endif

    // Random traffic with varying pipeline pressure
    for (int i = 0; i < 200; i++) rand_cycle(90, 0);
    for (int i = 0; i < 200; i++) rand_cycle(40, 0);
    for (int i = 0; i < 100; i++) rand_cycle(100, 0);

    // Reset held 2 cycles mid-traffic
    for (int i = 0; i < 10; i++) rand_cycle(95, 0);
    rand_cycle(95, 1);
    rand_cycle(95, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("t1_we", 64'(rf_we), 64'd0);
    check_val("t1_busy", 64'(busy_vec), 64'd0);
    check_val("t1_count", 64'(buf_count), 64'd0);
    check_val("t1_ready", 64'(lu_ready), 64'd1);
    tick();
    for (int i = 0; i < 100; i++) rand_cycle(70, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
